uart_tx_arbiter: RTL

Shares the single uart_main transmitter among NUM_REQ byte-stream requesters (command responder, debug log, status reporter, …). Round-robin grant with a per-grant burst limit so no requester can starve the others. A grant covers one message; a message ends on req_last or at MAX_BURST bytes. Sits between the requesters and the tx_input_data / tx_input_data_valid / tx_output_ready interface of uart_main.

---
 rtl/uart_tx_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Define UART_ARB_TIMEOUT_EN to let CAPTURE wait IDLE_TIMEOUT cycles for a slow producer.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int MAX_BURST    = 4,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         tx_input_data,
    output logic                      tx_input_data_valid,
    input  logic                      tx_output_ready,
    output logic                      tx_en,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                      busy,
    output logic [15:0]               tx_count
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_SEND
    } state_e;

    state_e            state_q, state_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [7:0]        beat_q, beat_d;
    logic [15:0]       count_q, count_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              hold_last_q, hold_last_d;
    logic              tx_en_q;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    logic [TW-1:0]     timer_q, timer_d;
`endif

    logic              win_found;
    logic [GW-1:0]     win_idx;
    logic [GW:0]       scan;
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic [GW-1:0]     next_ptr;

    // Rotating priority search; wrap by compare so non-power-of-two counts work.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, rr_ptr_q} + (GW+1)'(i);
            if (scan >= (GW+1)'(NUM_REQ)) begin
                scan = scan - (GW+1)'(NUM_REQ);
            end
            if (!win_found && req_valid[scan[GW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[GW-1:0];
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DATA_W +: DATA_W];
                req_ready[i] = (state_q == S_CAPTURE);
            end
        end
    end

    assign next_ptr = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        beat_d      = beat_q;
        count_d     = count_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
`ifdef UART_ARB_TIMEOUT_EN
        timer_d     = timer_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d = win_idx;
                    beat_d  = '0;
`ifdef UART_ARB_TIMEOUT_EN
                    timer_d = '0;
`endif
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (sel_valid) begin
                    hold_data_d = sel_data;
                    hold_last_d = sel_last;
                    beat_d      = beat_q + 8'd1;
                    state_d     = S_SEND;
                end else begin
`ifdef UART_ARB_TIMEOUT_EN
                    if (timer_q + TW'(1) == TW'(IDLE_TIMEOUT)) begin
                        rr_ptr_d = next_ptr;
                        state_d  = S_IDLE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
`else
                    rr_ptr_d = next_ptr;
                    state_d  = S_IDLE;
`endif
                end
            end
            S_SEND: begin
                if (tx_output_ready) begin
                    count_d = count_q + 16'd1;
                    if (hold_last_q || beat_q == 8'(MAX_BURST)) begin
                        rr_ptr_d = next_ptr;
                        state_d  = S_IDLE;
                    end else begin
`ifdef UART_ARB_TIMEOUT_EN
                        timer_d = '0;
`endif
                        state_d = S_CAPTURE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            beat_q      <= '0;
            count_q     <= '0;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            tx_en_q     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            beat_q      <= beat_d;
            count_q     <= count_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            tx_en_q     <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    assign tx_input_data_valid = (state_q == S_SEND);
    assign tx_input_data       = (state_q == S_SEND) ? hold_data_q : '0;
    assign tx_en               = tx_en_q;
    assign grant_id            = grant_q;
    assign busy                = (state_q != S_IDLE);
    assign tx_count            = count_q;

endmodule
